// File: rtl/axi_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module : axi_read_arbiter
// Brief  : Round-robin arbiter of I$/D$ refill reads onto one AXI read channel,
//          one transaction outstanding, with beat-count / ID protocol checking.
// Rev    : 1.0  initial release
// ============================================================================
module axi_read_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              c0_ar_valid,
    output logic              c0_ar_ready,
    input  logic [ADDR_W-1:0] c0_ar_addr,
    input  logic [3:0]        c0_ar_len,
    input  logic [2:0]        c0_ar_size,
    output logic              c0_r_valid,
    output logic [DATA_W-1:0] c0_r_data,
    output logic              c0_r_last,
    input  logic              c0_r_ready,
    input  logic              c1_ar_valid,
    output logic              c1_ar_ready,
    input  logic [ADDR_W-1:0] c1_ar_addr,
    input  logic [3:0]        c1_ar_len,
    input  logic [2:0]        c1_ar_size,
    output logic              c1_r_valid,
    output logic [DATA_W-1:0] c1_r_data,
    output logic              c1_r_last,
    input  logic              c1_r_ready,
    output logic [3:0]        arid,
    output logic [ADDR_W-1:0] araddr,
    output logic [3:0]        arlen,
    output logic [2:0]        arsize,
    output logic [1:0]        arburst,
    output logic [1:0]        arlock,
    output logic [3:0]        arcache,
    output logic [2:0]        arprot,
    output logic              arvalid,
    input  logic              arready,
    input  logic [3:0]        rid,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    input  logic              rlast,
    input  logic              rvalid,
    output logic              rready,
    output logic              proto_err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_AR   = 2'd1;
    localparam logic [1:0] S_R    = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_next;
    logic              r_last_grant;
    logic              r_grant;
    logic [ADDR_W-1:0] r_addr;
    logic [3:0]        r_len;
    logic [2:0]        r_size;
    logic [3:0]        r_beat_cnt;
    logic              r_proto_err;

    logic w_req_any;
    logic w_sel;
    logic w_beat;
    logic w_err_beat;
    logic w_unused;

    assign w_req_any = c0_ar_valid | c1_ar_valid;
    // On a tie the client that did not win last time takes the grant.
    assign w_sel     = (c0_ar_valid && c1_ar_valid) ? ~r_last_grant : c1_ar_valid;
    assign w_beat    = (r_state == S_R) && rvalid && rready;
    assign w_err_beat = (rid != {3'b000, r_grant}) ||
                        (rlast ? (r_beat_cnt != r_len) : (r_beat_cnt == r_len));
    assign w_unused  = ^rresp;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_req_any) w_next = S_AR;
            S_AR:    if (arready) w_next = S_R;
            S_R:     if (rvalid && rready && rlast) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // The request handshake is masked while reset is held so no client sees
    // an acceptance that the registers will never capture.
    always_comb begin
        c0_ar_ready = 1'b0;
        c1_ar_ready = 1'b0;
        arvalid     = 1'b0;
        rready      = 1'b0;
        c0_r_valid  = 1'b0;
        c1_r_valid  = 1'b0;
        c0_r_last   = 1'b0;
        c1_r_last   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_req_any && !reset) begin
                    c0_ar_ready = ~w_sel;
                    c1_ar_ready = w_sel;
                end
            end
            S_AR: arvalid = 1'b1;
            S_R: begin
                rready     = r_grant ? c1_r_ready : c0_r_ready;
                c0_r_valid = rvalid & ~r_grant;
                c1_r_valid = rvalid & r_grant;
                c0_r_last  = rlast & ~r_grant;
                c1_r_last  = rlast & r_grant;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_last_grant <= 1'b1;
            r_grant      <= 1'b0;
            r_addr       <= '0;
            r_len        <= 4'd0;
            r_size       <= 3'd0;
            r_beat_cnt   <= 4'd0;
            r_proto_err  <= 1'b0;
        end else begin
            if (r_state == S_IDLE && w_req_any) begin
                r_grant      <= w_sel;
                r_last_grant <= w_sel;
                r_addr       <= w_sel ? c1_ar_addr : c0_ar_addr;
                r_len        <= w_sel ? c1_ar_len  : c0_ar_len;
                r_size       <= w_sel ? c1_ar_size : c0_ar_size;
                r_beat_cnt   <= 4'd0;
            end
            if (w_beat) begin
                r_beat_cnt <= r_beat_cnt + 4'd1;
                if (w_err_beat) r_proto_err <= 1'b1;
            end
        end
    end

    assign arid      = {3'b000, r_grant};
    assign araddr    = r_addr;
    assign arlen     = r_len;
    assign arsize    = r_size;
    assign arburst   = 2'b01;
    assign arlock    = 2'b00;
    assign arcache   = 4'b0000;
    assign arprot    = 3'b000;
    assign c0_r_data = rdata;
    assign c1_r_data = rdata;
    assign proto_err = r_proto_err;

endmodule
`default_nettype wire

// File: tb/tb_axi_read_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : tb_axi_read_arbiter
// Brief  : Vector table, hand sequences and randomized model check of axi_read_arbiter.
// Rev    : 1.0  initial release
// ============================================================================
module tb_axi_read_arbiter;

    localparam logic [31:0] C_A0 = 32'h1FC0_0000;
    localparam logic [31:0] C_A1 = 32'h8000_1000;
    localparam logic [2:0]  C_S0 = 3'd2;
    localparam logic [2:0]  C_S1 = 3'd3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        c0_ar_valid, c0_ar_ready, c0_r_valid, c0_r_last, c0_r_ready;
    logic        c1_ar_valid, c1_ar_ready, c1_r_valid, c1_r_last, c1_r_ready;
    logic [31:0] c0_ar_addr, c1_ar_addr, c0_r_data, c1_r_data;
    logic [3:0]  c0_ar_len, c1_ar_len;
    logic [2:0]  c0_ar_size, c1_ar_size;
    logic [3:0]  arid, arlen, arcache, rid;
    logic [31:0] araddr, rdata;
    logic [2:0]  arsize, arprot;
    logic [1:0]  arburst, arlock, rresp;
    logic        arvalid, arready, rlast, rvalid, rready, proto_err;

    axi_read_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clock(clk), .reset(rst),
        .c0_ar_valid(c0_ar_valid), .c0_ar_ready(c0_ar_ready), .c0_ar_addr(c0_ar_addr),
        .c0_ar_len(c0_ar_len), .c0_ar_size(c0_ar_size), .c0_r_valid(c0_r_valid),
        .c0_r_data(c0_r_data), .c0_r_last(c0_r_last), .c0_r_ready(c0_r_ready),
        .c1_ar_valid(c1_ar_valid), .c1_ar_ready(c1_ar_ready), .c1_ar_addr(c1_ar_addr),
        .c1_ar_len(c1_ar_len), .c1_ar_size(c1_ar_size), .c1_r_valid(c1_r_valid),
        .c1_r_data(c1_r_data), .c1_r_last(c1_r_last), .c1_r_ready(c1_r_ready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid),
        .arready(arready), .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready), .proto_err(proto_err)
    );

    typedef struct {
        logic       rs, c0v, c1v;
        logic [3:0] len;
        logic       ar, rv, rl;
        logic [3:0] id;
        logic [7:0] d;
        logic       r0, r1;
        logic [1:0] e_ardy;
        logic       e_arv;
        logic [3:0] e_arid, e_arlen;
        logic       e_rr;
        logic [1:0] e_rv;
        logic       e_rl, e_perr;
    } vec_t;

    vec_t tbl[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic vec_t mkv(input int rs, c0, c1, ln, ar, rv, rl, id, d, r0, r1,
                                 input int ea, eav, eid, eln, err, erv, erl, ep);
        vec_t f;
        f.rs = rs[0]; f.c0v = c0[0]; f.c1v = c1[0]; f.len = ln[3:0];
        f.ar = ar[0]; f.rv = rv[0]; f.rl = rl[0]; f.id = id[3:0]; f.d = d[7:0];
        f.r0 = r0[0]; f.r1 = r1[0];
        f.e_ardy = ea[1:0]; f.e_arv = eav[0]; f.e_arid = eid[3:0]; f.e_arlen = eln[3:0];
        f.e_rr = err[0]; f.e_rv = erv[1:0]; f.e_rl = erl[0]; f.e_perr = ep[0];
        return f;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input bit ok, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s got=%h required=%h", name, got, exp);
        end
    endtask

    task automatic run_row(input vec_t r, input int idx);
        bit ok;
        rst = r.rs; c0_ar_valid = r.c0v; c1_ar_valid = r.c1v;
        c0_ar_len = r.len; c1_ar_len = r.len;
        c0_ar_addr = C_A0; c1_ar_addr = C_A1; c0_ar_size = C_S0; c1_ar_size = C_S1;
        arready = r.ar; rvalid = r.rv; rlast = r.rl; rid = r.id;
        rdata = {24'h0, r.d}; c0_r_ready = r.r0; c1_r_ready = r.r1;
        #1;
        ok = ({c1_ar_ready, c0_ar_ready} == r.e_ardy) && (arvalid == r.e_arv) &&
             (rready == r.e_rr) && ({c1_r_valid, c0_r_valid} == r.e_rv) && (proto_err == r.e_perr);
        if (r.e_arv)
            ok = ok && (arid == r.e_arid) && (arlen == r.e_arlen) &&
                 (araddr == ((r.e_arid == 4'd0) ? C_A0 : C_A1)) &&
                 (arsize == ((r.e_arid == 4'd0) ? C_S0 : C_S1));
        if (r.e_rv[0]) ok = ok && (c0_r_last == r.e_rl) && (c0_r_data == {24'h0, r.d});
        if (r.e_rv[1]) ok = ok && (c1_r_last == r.e_rl) && (c1_r_data == {24'h0, r.d});
        check($sformatf("row%0d", idx), ok,
              {32'h0, 2'b0, c1_ar_ready, c0_ar_ready, arvalid, arid, arlen, rready,
               c1_r_valid, c0_r_valid, c1_r_last, c0_r_last, proto_err, 12'h0},
              {32'h0, 2'b0, r.e_ardy, r.e_arv, r.e_arid, r.e_arlen, r.e_rr,
               r.e_rv, r.e_rv[1] & r.e_rl, r.e_rv[0] & r.e_rl, r.e_perr, 12'h0});
    endtask

    task automatic idle_inputs();
        c0_ar_valid = 1'b0; c1_ar_valid = 1'b0; arready = 1'b0; rvalid = 1'b0;
        rlast = 1'b0; rid = 4'd0; c0_r_ready = 1'b0; c1_r_ready = 1'b0;
    endtask

    // Transaction-level reference for the random phase.
    bit          m_busy, m_sent, m_g, m_lastg, m_err;
    int          m_len, m_cnt;
    logic [31:0] m_addr;
    logic [2:0]  m_size;

    initial begin
        rst = 1'b1; rresp = 2'b00; rdata = '0;
        c0_ar_addr = C_A0; c1_ar_addr = C_A1; c0_ar_len = 4'd0; c1_ar_len = 4'd0;
        c0_ar_size = C_S0; c1_ar_size = C_S1;
        idle_inputs();
        c0_ar_valid = 1'b1; c1_ar_valid = 1'b1;
        tick(); tick();
        check("reset_state",
              !c0_ar_ready && !c1_ar_ready && !arvalid && !rready && !c0_r_valid &&
              !c1_r_valid && !proto_err && arburst == 2'b01 && arlock == 2'b00 &&
              arcache == 4'd0 && arprot == 3'd0,
              {51'h0, c1_ar_ready, c0_ar_ready, arvalid, rready, c1_r_valid, c0_r_valid,
               proto_err, arburst, arlock, arprot},
              {51'h0, 7'b0, 2'b01, 2'b00, 3'b000});

        // rs c0 c1 len ar rv rl rid d r0 r1 | ardy arv arid arlen rr rv rl perr
        tbl.push_back(mkv(0,1,0,3, 0,0,0,0,0,0,0,     'b01,0,0,0,0,'b00,0,0));
        tbl.push_back(mkv(0,0,0,3, 1,0,0,0,0,0,0,     'b00,1,0,3,0,'b00,0,0));
        tbl.push_back(mkv(0,0,0,3, 0,1,0,0,'hA0,1,0,  'b00,0,0,0,1,'b01,0,0));
        tbl.push_back(mkv(0,0,0,3, 0,1,0,0,'hA1,1,0,  'b00,0,0,0,1,'b01,0,0));
        tbl.push_back(mkv(0,0,0,3, 0,1,0,0,'hA2,1,0,  'b00,0,0,0,1,'b01,0,0));
        tbl.push_back(mkv(0,0,0,3, 0,1,1,0,'hA3,1,0,  'b00,0,0,0,1,'b01,1,0));
        tbl.push_back(mkv(0,0,0,3, 0,1,1,5,'hEE,1,1,  'b00,0,0,0,0,'b00,0,0));
        tbl.push_back(mkv(0,0,0,0, 0,0,0,0,0,0,0,     'b00,0,0,0,0,'b00,0,0));
        tbl.push_back(mkv(1,1,1,0, 0,0,0,0,0,0,0,     'b00,0,0,0,0,'b00,0,0));
        tbl.push_back(mkv(0,1,1,0, 0,0,0,0,0,0,0,     'b01,0,0,0,0,'b00,0,0));
        tbl.push_back(mkv(0,1,1,0, 1,0,0,0,0,0,0,     'b00,1,0,0,0,'b00,0,0));
        tbl.push_back(mkv(0,1,1,0, 0,1,1,0,'hB0,1,0,  'b00,0,0,0,1,'b01,1,0));
        tbl.push_back(mkv(0,1,1,0, 0,0,0,0,0,0,0,     'b10,0,0,0,0,'b00,0,0));
        tbl.push_back(mkv(0,1,1,0, 1,0,0,0,0,0,0,     'b00,1,1,0,0,'b00,0,0));
        tbl.push_back(mkv(0,1,1,0, 0,1,1,1,'hB1,0,1,  'b00,0,0,0,1,'b10,1,0));
        tbl.push_back(mkv(0,1,1,0, 0,0,0,0,0,0,0,     'b01,0,0,0,0,'b00,0,0));
        for (int k = 0; k < 5; k++)
            tbl.push_back(mkv(0,0,0,7, 0,0,0,0,0,0,0, 'b00,1,0,0,0,'b00,0,0));
        tbl.push_back(mkv(0,0,0,7, 1,0,0,0,0,0,0,     'b00,1,0,0,0,'b00,0,0));
        tbl.push_back(mkv(0,0,0,7, 0,1,1,0,'hC0,1,0,  'b00,0,0,0,1,'b01,1,0));
        tbl.push_back(mkv(0,0,1,1, 0,0,0,0,0,0,0,     'b10,0,0,0,0,'b00,0,0));
        tbl.push_back(mkv(0,0,0,1, 1,0,0,0,0,0,0,     'b00,1,1,1,0,'b00,0,0));
        tbl.push_back(mkv(0,0,0,1, 0,1,0,1,'hC1,0,1,  'b00,0,0,0,1,'b10,0,0));
        tbl.push_back(mkv(0,0,0,1, 0,1,1,1,'hC2,1,0,  'b00,0,0,0,0,'b10,1,0));
        tbl.push_back(mkv(0,0,0,1, 0,1,1,1,'hC2,0,1,  'b00,0,0,0,1,'b10,1,0));
        tbl.push_back(mkv(0,1,0,1, 0,0,0,0,0,0,0,     'b01,0,0,0,0,'b00,0,0));
        tbl.push_back(mkv(0,0,0,1, 1,0,0,0,0,0,0,     'b00,1,0,1,0,'b00,0,0));
        tbl.push_back(mkv(0,0,0,1, 0,1,1,0,'hD0,1,0,  'b00,0,0,0,1,'b01,1,0));
        tbl.push_back(mkv(0,0,0,0, 0,0,0,0,0,0,0,     'b00,0,0,0,0,'b00,0,1));
        tbl.push_back(mkv(0,0,1,0, 0,0,0,0,0,0,0,     'b10,0,0,0,0,'b00,0,1));
        tbl.push_back(mkv(0,0,0,0, 1,0,0,0,0,0,0,     'b00,1,1,0,0,'b00,0,1));
        tbl.push_back(mkv(0,0,0,0, 0,1,1,1,'hD1,0,1,  'b00,0,0,0,1,'b10,1,1));
        tbl.push_back(mkv(0,0,0,0, 0,0,0,0,0,0,0,     'b00,0,0,0,0,'b00,0,1));
        tbl.push_back(mkv(1,0,0,0, 0,0,0,0,0,0,0,     'b00,0,0,0,0,'b00,0,0));
        tbl.push_back(mkv(0,0,1,0, 0,0,0,0,0,0,0,     'b10,0,0,0,0,'b00,0,0));
        tbl.push_back(mkv(0,0,0,0, 1,0,0,0,0,0,0,     'b00,1,1,0,0,'b00,0,0));
        tbl.push_back(mkv(0,0,0,0, 0,1,1,0,'hE0,1,1,  'b00,0,0,0,1,'b10,1,0));
        tbl.push_back(mkv(0,0,0,0, 0,0,0,0,0,0,0,     'b00,0,0,0,0,'b00,0,1));

        for (int i = 0; i < tbl.size(); i++) begin
            run_row(tbl[i], i);
            tick();
        end

        // Reset mid-burst: two beats of four taken (first with a bad ID), then async reset.
        idle_inputs(); c0_ar_len = 4'd3; c0_ar_valid = 1'b1;
        #1 check("mb_grant", c0_ar_ready, {63'h0, c0_ar_ready}, 64'h1);
        tick(); idle_inputs(); arready = 1'b1;
        tick(); idle_inputs(); rvalid = 1'b1; c0_r_ready = 1'b1; rid = 4'd3;
        tick(); rid = 4'd0;
        #1 check("mb_beat2", c0_r_valid && rready, {62'h0, c0_r_valid, rready}, 64'h3);
        tick();
        #1 check("mb_pending", c0_r_valid && proto_err, {62'h0, c0_r_valid, proto_err}, 64'h3);
        rst = 1'b1;
        #1 check("mb_async_clear",
                 !arvalid && !rready && !c0_r_valid && !c1_r_valid && !proto_err && arburst == 2'b01,
                 {58'h0, arvalid, rready, c0_r_valid, c1_r_valid, proto_err, arburst[0]}, 64'h1);
        tick(); rst = 1'b0; idle_inputs(); c0_ar_len = 4'd2; c0_ar_valid = 1'b1;
        #1 check("mb_regrant", c0_ar_ready && !c1_ar_ready, {62'h0, c1_ar_ready, c0_ar_ready}, 64'h1);
        tick(); idle_inputs();
        #1 check("mb_arvalid", arvalid && arid == 4'd0 && arlen == 4'd2 && araddr == C_A0,
                 {arid, arlen, araddr, 23'h0, arvalid}, {4'd0, 4'd2, C_A0, 23'h0, 1'b1});

        // Randomized phase against the transaction-level model.
        tick(); rst = 1'b1; idle_inputs(); tick(); rst = 1'b0;
        m_busy = 0; m_sent = 0; m_g = 0; m_lastg = 1; m_err = 0; m_len = 0; m_cnt = 0;
        m_addr = '0; m_size = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            bit         any, gsel, dph, e_arv, e_rr, ok;
            logic [1:0] e_ardy, e_rv;
            c0_ar_valid = ($urandom % 3) == 0;
            c1_ar_valid = ($urandom % 3) == 0;
            c0_ar_addr  = $urandom; c1_ar_addr = $urandom;
            c0_ar_len   = 4'($urandom_range(0, 4)); c1_ar_len = 4'($urandom_range(0, 4));
            c0_ar_size  = 3'($urandom); c1_ar_size = 3'($urandom);
            arready     = ($urandom % 2) == 0;
            rvalid      = ($urandom % 5) < 3;
            rdata       = $urandom;
            c0_r_ready  = ($urandom % 4) != 0;
            c1_r_ready  = ($urandom % 4) != 0;
            rid         = (($urandom % 12) == 0) ? 4'($urandom) : {3'b000, m_g};
            rlast       = (($urandom % 10) == 0) ? 1'($urandom) : (m_cnt == m_len);
            #1;
            any    = c0_ar_valid || c1_ar_valid;
            gsel   = (c0_ar_valid && c1_ar_valid) ? !m_lastg : c1_ar_valid;
            e_ardy = (!m_busy && any) ? (gsel ? 2'b10 : 2'b01) : 2'b00;
            e_arv  = m_busy && !m_sent;
            dph    = m_busy && m_sent;
            e_rr   = dph && (m_g ? c1_r_ready : c0_r_ready);
            e_rv   = {dph && m_g && rvalid, dph && !m_g && rvalid};
            ok = ({c1_ar_ready, c0_ar_ready} == e_ardy) && (arvalid == e_arv) &&
                 (rready == e_rr) && ({c1_r_valid, c0_r_valid} == e_rv) && (proto_err == m_err);
            if (e_arv)
                ok = ok && (araddr == m_addr) && (int'(arlen) == m_len) &&
                     (arsize == m_size) && (int'(arid) == int'(m_g));
            if (e_rv[0]) ok = ok && (c0_r_data == rdata) && (c0_r_last == rlast);
            if (e_rv[1]) ok = ok && (c1_r_data == rdata) && (c1_r_last == rlast);
            check($sformatf("rand%0d", cyc), ok,
                  {57'h0, c1_ar_ready, c0_ar_ready, arvalid, rready, c1_r_valid, c0_r_valid, proto_err},
                  {57'h0, e_ardy, e_arv, e_rr, e_rv, m_err});
            if (!m_busy && any) begin
                m_busy = 1; m_sent = 0; m_g = gsel; m_lastg = gsel; m_cnt = 0;
                m_len  = gsel ? int'(c1_ar_len) : int'(c0_ar_len);
                m_addr = gsel ? c1_ar_addr : c0_ar_addr;
                m_size = gsel ? c1_ar_size : c0_ar_size;
            end else if (e_arv && arready) begin
                m_sent = 1;
            end else if (dph && rvalid && e_rr) begin
                if (int'(rid) != int'(m_g) || (rlast != (m_cnt == m_len))) m_err = 1;
                m_cnt = (m_cnt + 1) % 16;
                if (rlast) m_busy = 0;
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
